// File: rtl/tpu_pkg.sv
// Shared constants and the feeder state encoding used across the
// global-buffer-to-systolic-array datapath.
package tpu_pkg;
    localparam int LANES        = 5;
    localparam int DATA_W       = 8;
    localparam int WORD_W       = LANES * DATA_W;
    localparam int ADDR_W       = 8;
    localparam int LEN_W        = 4;
    // Read latency + stage register + deepest lane delay.
    localparam int DRAIN_CYCLES = LANES + 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } feeder_state_e;
endpackage

// File: rtl/gbuff_skew_feeder_if.sv
// Launch, global-buffer read port and skewed lane outputs of one feeder.
// master is the feeder side; slave is the buffer/controller side.
interface gbuff_skew_feeder_if;
    import tpu_pkg::*;

    logic                  start;
    logic [ADDR_W-1:0]     base_addr;
    logic [LEN_W-1:0]      len;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [WORD_W-1:0]     rd_data;
    logic [WORD_W-1:0]     lane_data;
    logic [LANES-1:0]      lane_valid;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, base_addr, len, rd_data,
        output rd_en, rd_addr, lane_data, lane_valid, busy, done
    );

    modport slave (
        output start, base_addr, len, rd_data,
        input  rd_en, rd_addr, lane_data, lane_valid, busy, done
    );
endinterface

// File: rtl/skew_delay_line.sv
// DEPTH-stage register chain carrying one lane element plus its valid bit;
// DEPTH=0 is a plain pass-through.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);
    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused;
            assign w_unused = clk ^ rst;
            assign o_data   = i_data;
            assign o_valid  = i_valid;
        end else begin : g_regs
            logic [WIDTH-1:0] r_data [DEPTH];
            logic [DEPTH-1:0] r_valid;

            // NOTE: these are pipeline registers, not storage, so each stage is
            // cleared on rst to guarantee zero padding after an abort.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < DEPTH; k++) r_data[k] <= '0;
                    r_valid <= '0;
                end else begin
                    r_data[0]  <= i_data;
                    r_valid[0] <= i_valid;
                    for (int k = 1; k < DEPTH; k++) begin
                        r_data[k]  <= r_data[k-1];
                        r_valid[k] <= r_valid[k-1];
                    end
                end
            end

            assign o_data  = r_data[DEPTH-1];
            assign o_valid = r_valid[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/gbuff_skew_feeder.sv
// Streams len words from a global buffer and presents them to the systolic
// array edge as diagonally skewed, zero-padded lanes (lane i delayed i cycles).
module gbuff_skew_feeder
    import tpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    gbuff_skew_feeder_if.master  bus
);
    feeder_state_e       r_state;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_rd_en;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_done;
    logic                r_rd_vld;
    logic                r_stage_vld;
    logic [WORD_W-1:0]   r_stage_data;
    logic [DATA_W-1:0]   w_lane_data [LANES];
    logic                w_lane_vld  [LANES];

    // r_cnt counts issued reads in READ, then drain cycles in DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rd_addr <= '0;
            r_rd_en   <= 1'b0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_busy <= 1'b1;
                        r_cnt  <= '0;
                        if (bus.len == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= READ;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= bus.base_addr;
                            r_len     <= bus.len;
                        end
                    end
                end
                READ: begin
                    if (r_cnt == r_len - 1'b1) begin
                        r_rd_en <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= DRAIN;
                    end else begin
                        r_cnt     <= r_cnt + 1'b1;
                        r_rd_addr <= r_rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (r_cnt == LEN_W'(DRAIN_CYCLES - 1)) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: non-valid cycles load zeros, so the PEs never see stale bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_vld     <= 1'b0;
            r_stage_vld  <= 1'b0;
            r_stage_data <= '0;
        end else begin
            r_rd_vld     <= r_rd_en;
            r_stage_vld  <= r_rd_vld;
            r_stage_data <= r_rd_vld ? bus.rd_data : '0;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        skew_delay_line #(
            .DEPTH (i),
            .WIDTH (DATA_W)
        ) u_delay (
            .clk     (clk),
            .rst     (rst),
            .i_data  (r_stage_data[WORD_W-1-DATA_W*i -: DATA_W]),
            .i_valid (r_stage_vld),
            .o_data  (w_lane_data[i]),
            .o_valid (w_lane_vld[i])
        );
    end

    always_comb begin
        bus.lane_data  = '0;
        bus.lane_valid = '0;
        for (int i = 0; i < LANES; i++) begin
            bus.lane_data[WORD_W-1-DATA_W*i -: DATA_W] = w_lane_data[i];
            bus.lane_valid[i]                          = w_lane_vld[i];
        end
    end

    assign bus.rd_en   = r_rd_en;
    assign bus.rd_addr = r_rd_addr;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_gbuff_skew_feeder.sv
// Self-checking bench: hand-derived vector table for the reference run plus
// randomized runs compared against a cycle-timing model of the feeder.
module tb_gbuff_skew_feeder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    gbuff_skew_feeder_if bus ();

    gbuff_skew_feeder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [39:0] mem [256];
    int n_tests = 0;
    int n_fail  = 0;

    // Synchronous-read buffer; random junk on rd_data when not reading.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
        else           bus.rd_data <= 40'({$urandom, $urandom});
    end

    typedef struct {
        logic        rd_en;
        logic [7:0]  addr;
        logic [4:0]  valid;
        logic [39:0] data;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tab [14];

    function automatic vec_t mk(input logic e, input logic [7:0] a, input logic [4:0] v,
                                input logic [39:0] d, input logic b, input logic dn);
        vec_t r;
        r.rd_en = e; r.addr = a; r.valid = v; r.data = d; r.busy = b; r.done = dn;
        return r;
    endfunction

    // {rd_en, rd_addr (only while reading), lane_valid, busy, done, lane_data}
    function automatic logic [55:0] obs();
        return {bus.rd_en, (bus.rd_en ? bus.rd_addr : 8'h00), bus.lane_valid,
                bus.busy, bus.done, bus.lane_data};
    endfunction

    function automatic logic [55:0] obs_raw();
        return {bus.rd_en, bus.rd_addr, bus.lane_valid, bus.busy, bus.done, bus.lane_data};
    endfunction

    // Expected outputs c cycles after start, from the word/lane timing rules.
    function automatic logic [55:0] model_obs(input logic [7:0] base, input int len, input int c);
        logic        e, b, dn;
        logic [7:0]  a;
        logic [4:0]  v;
        logic [39:0] d;
        e  = (c >= 1) && (c <= len);
        a  = e ? 8'((int'(base) + c - 1) % 256) : 8'h00;
        b  = (len == 0) ? (c == 1) : ((c >= 1) && (c <= len + 7));
        dn = (len == 0) ? (c == 1) : (c == len + 7);
        v  = '0;
        d  = '0;
        for (int i = 0; i < 5; i++) begin
            int j;
            j = c - 3 - i;
            if (j >= 0 && j < len) begin
                v[i]              = 1'b1;
                d[39-8*i -: 8]    = mem[8'((int'(base) + j) % 256)][39-8*i -: 8];
            end
        end
        return {e, a, v, b, dn, d};
    endfunction

    task automatic check(input string name, input int c, input logic [55:0] act, input logic [55:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at cycle 13 (idle again).
    task automatic run_table(input string name);
        bus.start = 1'b1; bus.base_addr = 8'h00; bus.len = 4'd5;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) begin
                @(negedge clk);
                bus.start = 1'b0;
            end
            check(name, c, obs(), {tab[c].rd_en, tab[c].addr, tab[c].valid,
                                   tab[c].busy, tab[c].done, tab[c].data});
        end
    endtask

    // Optional second start at cycle extra_c must be ignored. Returns at len+8.
    task automatic run_model(input string name, input logic [7:0] base, input logic [3:0] len,
                             input int extra_c);
        bus.start = 1'b1; bus.base_addr = base; bus.len = len;
        for (int c = 0; c <= int'(len) + 8; c++) begin
            if (c > 0) begin
                @(negedge clk);
                bus.start = (c == extra_c);
                if (c == extra_c) begin
                    bus.base_addr = 8'h40;
                    bus.len       = 4'd7;
                end
            end
            check(name, c, obs(), model_obs(base, int'(len), c));
        end
        bus.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0]  = mk(0, 8'h00, 5'b00000, 40'h00_00_00_00_00, 0, 0);
        tab[1]  = mk(1, 8'h00, 5'b00000, 40'h00_00_00_00_00, 1, 0);
        tab[2]  = mk(1, 8'h01, 5'b00000, 40'h00_00_00_00_00, 1, 0);
        tab[3]  = mk(1, 8'h02, 5'b00001, 40'h00_00_00_00_00, 1, 0);
        tab[4]  = mk(1, 8'h03, 5'b00011, 40'h01_01_00_00_00, 1, 0);
        tab[5]  = mk(1, 8'h04, 5'b00111, 40'h00_00_00_00_00, 1, 0);
        tab[6]  = mk(0, 8'h00, 5'b01111, 40'h00_00_00_00_00, 1, 0);
        tab[7]  = mk(0, 8'h00, 5'b11111, 40'h01_01_00_00_00, 1, 0);
        tab[8]  = mk(0, 8'h00, 5'b11110, 40'h00_00_01_00_01, 1, 0);
        tab[9]  = mk(0, 8'h00, 5'b11100, 40'h00_00_01_01_01, 1, 0);
        tab[10] = mk(0, 8'h00, 5'b11000, 40'h00_00_00_01_00, 1, 0);
        tab[11] = mk(0, 8'h00, 5'b10000, 40'h00_00_00_00_01, 1, 0);
        tab[12] = mk(0, 8'h00, 5'b00000, 40'h00_00_00_00_00, 1, 1);
        tab[13] = mk(0, 8'h00, 5'b00000, 40'h00_00_00_00_00, 0, 0);

        for (int i = 0; i < 256; i++) mem[i] = 40'({$urandom, $urandom});
        mem[0] = 40'h00_01_00_00_00;
        mem[1] = 40'h01_00_00_00_01;
        mem[2] = 40'h00_00_00_00_01;
        mem[3] = 40'h00_01_01_01_00;
        mem[4] = 40'h01_00_01_01_01;

        bus.start = 1'b0; bus.base_addr = '0; bus.len = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_hold", 0, obs_raw(), '0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_release", 0, obs_raw(), '0);

        run_table("ref_run");
        run_model("busy_start", 8'h00, 4'd5, 4);
        run_table("start_at_13");
        run_model("wrap", 8'hFE, 4'd4, -1);
        run_model("len0", 8'h10, 4'd0, -1);

        // Asynchronous reset in cycle 5 of a len=5 run.
        bus.start = 1'b1; bus.base_addr = 8'h00; bus.len = 4'd5;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("rst_mid", 5, obs_raw(), '0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("post_rst_idle", c, obs(), '0);
        end
        run_table("after_rst");

        for (int r = 0; r < 24; r++) begin
            logic [7:0] base;
            logic [3:0] len;
            int         extra;
            for (int i = 0; i < 256; i++) mem[i] = 40'({$urandom, $urandom});
            base  = 8'($urandom_range(0, 255));
            len   = 4'($urandom_range(0, 15));
            extra = -1;
            if ($urandom_range(0, 1) == 1)
                extra = int'($urandom_range(1, (len == 0) ? 1 : int'(len) + 7));
            run_model("random", base, len, extra);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gbuff_skew_feeder.md
# gbuff_skew_feeder

Streams a run of 40-bit words out of a global buffer (GBUFF_A or GBUFF_B) and presents them to the 5x5 systolic array as diagonally skewed, zero-padded lanes. It sits directly upstream of the PE array edge: one instance feeds the row inputs from GBUFF_A, and a second feeds the column inputs from GBUFF_B. Each word packs five 8-bit elements, with the MSB byte [39:32] as element 0 and the LSB byte [7:0] as element 4. Lane i is delayed i cycles relative to lane 0, so the array receives the staggered wavefront it requires.

## Interface
- LANES, 5, number of array lanes / elements per word
- DATA_W, 8, element width in bits
- ADDR_W, 8, global buffer address width
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle launch pulse; sampled only in IDLE
- base_addr  in  ADDR_W  address of word 0; sampled with start
- len  in  4  number of words to stream, 0..15; sampled with start
- rd_en  out  1  global buffer read strobe
- rd_addr  out  ADDR_W  global buffer read address
- rd_data  in  LANES*DATA_W  buffer data, valid the cycle after rd_en (synchronous read)
- lane_data  out  LANES*DATA_W  skewed element outputs; lane i at [39-8i:32-8i]
- lane_valid  out  LANES  per-lane valid; bit i qualifies lane i
- busy  out  1  high from the cycle after start is accepted through the done cycle
- done  out  1  one-cycle completion pulse

## Operation
- Reset values: rd_en=0, rd_addr=0, lane_data=0, lane_valid=0, busy=0, done=0, state=IDLE, all skew registers 0.
- FSM states are IDLE, READ, DRAIN and DONE.
- IDLE -> READ when start=1 and len!=0. Latch base_addr and len, and clear the word counter.
- IDLE -> DONE when start=1 and len=0. No reads are issued.
- READ: assert rd_en for exactly len consecutive cycles. rd_addr = base_addr + j for word j, computed mod 2^ADDR_W so the address wraps 255->0. After the last read, go to DRAIN.
- DRAIN: wait until lane 4 of the last word has been presented, then go to DONE.
- DONE: pulse done for one cycle, then return to IDLE.
- start is ignored whenever the state is not IDLE. No queuing.
- Data path: capture rd_data into a stage register with a valid bit. Lane i then passes through i extra register stages (a delay line of depth i).
- Lane i outputs 0 with lane_valid[i]=0 whenever it carries no word. This zero padding is mandatory, because the PEs accumulate unconditionally.
- No arithmetic on the data. Bytes pass through bit-exact.
- Asynchronous rst mid-stream aborts immediately. All outputs and the FSM return to reset values, done is not pulsed, and in-flight data is discarded.

## Timing
- Cycle 0 is the cycle in which start=1 is sampled.
- Word j read: rd_en=1 and rd_addr=base+j in cycle 1+j.
- rd_data for word j is present in cycle 2+j.
- Lane i of word j appears on lane_data with lane_valid[i]=1 in cycle 3+j+i.
- Lane 0 is valid in cycles 3..len+2. Lane 4 is valid in cycles 7..len+6.
- done=1 in cycle len+7, and busy drops in cycle len+8.
- A new start is accepted from cycle len+8 onward.
- len=0: done=1 in cycle 1, lane_valid stays 0 and rd_en stays 0.
- Throughput: one word per cycle with no bubbles. Back-to-back runs have a gap of 8 cycles (start to first read = 1, plus drain).

## Structure
- Shared package tpu_pkg holds LANES, DATA_W, WORD_W = LANES*DATA_W, and the feeder state enum (IDLE, READ, DRAIN, DONE).
- Sub-module skew_delay_line: a parameterised DEPTH-stage register chain carrying data and valid. It clears asynchronously on rst, and DEPTH=0 means pass-through. The feeder instantiates it once per lane with DEPTH=i.
- The FSM, counter and address generator stay in gbuff_skew_feeder.

## Test plan
- Load buffer[0..4] = 40'h00_01_00_00_00, 40'h01_00_00_00_01, 40'h00_00_00_00_01, 40'h00_01_01_01_00, 40'h01_00_01_01_01, then start with base=0, len=5 -> rd_addr 0..4 in cycles 1..5.
  - Lane 0 shows 00,01,00,00,01 in cycles 3..7.
  - Lane 4 shows 00,01,01,00,01 in cycles 7..11.
  - done in cycle 12.
- Zero padding, same run -> lane_data[31:24] (lane 1) = 0 with lane_valid[1]=0 in cycles 3 and 9.
- Wrap: base=8'hFE, len=4 -> rd_addr sequence FE, FF, 00, 01, and lane data matches those words.
- len=0 -> done=1 in cycle 1, no rd_en, all lane_valid stay 0.
- Start while busy: a second start in cycle 4 of a len=5 run is ignored, with a single done in cycle 12 and the next start accepted in cycle 13.
- Reset mid-run: assert rst in cycle 5 of a len=5 run -> all outputs are 0 in that cycle, done never pulses, and a fresh start after release behaves as in the first test.
